// File: rtl/keypad_pkg.sv
// Shared types, key map and snapshot helpers for the 4x4 hex keypad scanner.
`timescale 1ns/1ps
package keypad_pkg;

  typedef enum logic [1:0] {RELEASED, HELD, LOCKED} kp_state_t;

  // Indexed by {row, col}: entry 4*row+col. Row 0 is the top row of the pad.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'h0) && ((v & (v - 16'h1)) == 16'h0);
  endfunction

  function automatic logic [3:0] onehot_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'h0;
    for (int i = 0; i < 16; i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/kp_debounce.sv
// Frame-level debouncer: a 16-bit key snapshot must repeat DEB_FRAMES frames
// in a row before it is published as stable.
`timescale 1ns/1ps
module kp_debounce #(
  parameter int DEB_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] raw,
  input  logic        frame_end,
  output logic [15:0] stable,
  output logic        stable_upd
);

  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_FRAMES);

  logic [15:0]   prev_raw_reg;
  logic [15:0]   stable_reg;
  logic [CW-1:0] same_cnt_reg, same_cnt_next;
  logic          upd_reg, upd_next;
  logic          same;

  assign same = (raw == prev_raw_reg);

  always_comb begin
    same_cnt_next = same_cnt_reg;
    upd_next      = 1'b0;
    if (frame_end) begin
      if (same)
        same_cnt_next = (same_cnt_reg == DEB_MAX) ? DEB_MAX : same_cnt_reg + CW'(1);
      else
        same_cnt_next = CW'(1);
      // Publish once per stable run, not on every saturated frame.
      upd_next = (same_cnt_next == DEB_MAX) && !(same && (same_cnt_reg == DEB_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_raw_reg <= '0;
      same_cnt_reg <= '0;
      stable_reg   <= '0;
      upd_reg      <= 1'b0;
    end else begin
      upd_reg <= upd_next;
      if (frame_end) begin
        prev_raw_reg <= raw;
        same_cnt_reg <= same_cnt_next;
      end
      if (upd_next)
        stable_reg <= raw;
    end
  end

  assign stable     = stable_reg;
  assign stable_upd = upd_reg;

endmodule

// File: rtl/hex_keypad.sv
// 4x4 hex keypad scanner: row scan, column sync, debounce, press FSM and a
// 4-digit shift-in entry register feeding the display driver.
`timescale 1ns/1ps
module hex_keypad
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic [3:0]  KP_ROW,
  input  logic [3:0]  KP_COL,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] data
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    col_meta_reg, col_sync_reg;
  logic [SW-1:0] slot_reg;
  logic [1:0]    row_reg;
  logic [15:0]   raw_reg, raw_next;
  logic          capture, frame_end;

  logic [15:0]   stable;
  logic          stable_upd;

  kp_state_t     state_reg, state_next;
  logic          emit;
  logic [3:0]    hit_code;
  logic          key_valid_reg;
  logic [3:0]    key_code_reg;
  logic [15:0]   data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign KP_ROW[gi] = (row_reg != 2'(gi));
    end
  endgenerate

  assign capture   = (slot_reg == SLOT_LAST);
  assign frame_end = capture && (row_reg == 2'd3);

  // The debouncer sees the snapshot including the row captured this edge.
  always_comb begin
    raw_next = raw_reg;
    if (capture)
      raw_next[{row_reg, 2'b00} +: 4] = ~col_sync_reg;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      col_meta_reg <= 4'hF;
      col_sync_reg <= 4'hF;
      slot_reg     <= '0;
      row_reg      <= '0;
      raw_reg      <= '0;
    end else begin
      col_meta_reg <= KP_COL;
      col_sync_reg <= col_meta_reg;
      raw_reg      <= raw_next;
      if (capture) begin
        slot_reg <= '0;
        row_reg  <= row_reg + 2'd1;
      end else begin
        slot_reg <= slot_reg + SW'(1);
      end
    end
  end

  kp_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_debounce (
    .clk        (CLK),
    .rstn       (RSTN),
    .raw        (raw_next),
    .frame_end  (frame_end),
    .stable     (stable),
    .stable_upd (stable_upd)
  );

  assign hit_code = KEY_MAP[onehot_index(stable)];

  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    if (stable_upd) begin
      case (state_reg)
        RELEASED: begin
          if (is_onehot(stable)) begin
            emit       = 1'b1;
            state_next = HELD;
          end else if (stable != 16'h0) begin
            state_next = LOCKED;
          end
        end
        HELD, LOCKED: if (stable == 16'h0) state_next = RELEASED;
        default:      state_next = RELEASED;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_reg     <= RELEASED;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'h0;
      data_reg      <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      key_valid_reg <= emit;
      if (emit) begin
        key_code_reg <= hit_code;
        data_reg     <= {data_reg[11:0], hit_code};
      end
    end
  end

  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign key_held  = (state_reg == HELD) || (state_reg == LOCKED);
  assign data      = data_reg;

endmodule

// File: tb/tb_hex_keypad.sv
// Directed bench for hex_keypad with a resistive-matrix keypad model
// (SCAN_DIV=8, DEB_FRAMES=3, so one frame is 32 cycles).
`timescale 1ns/1ps
module tb_hex_keypad;

  localparam int SCAN_DIV   = 8;
  localparam int DEB_FRAMES = 3;
  localparam int FRAME      = 4 * SCAN_DIV;
  localparam int NSTEP      = 19;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic [15:0] data;
    logic        held;
  } step_t;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [3:0]  KP_ROW;
  logic [3:0]  KP_COL;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] data;

  logic [15:0] keys = 16'h0;
  int          n_vec = 0;
  int          n_err = 0;
  int          pulse_cnt = 0;

  hex_keypad #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .KP_ROW    (KP_ROW),
    .KP_COL    (KP_COL),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .data      (data)
  );

  always #5 CLK = ~CLK;

  // A pressed key shorts its column to its row; only the driven-low row matters.
  always_comb begin
    KP_COL = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!KP_ROW[r] && keys[4*r+c]) KP_COL[c] = 1'b0;
  end

  always @(negedge CLK)
    if (key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(posedge CLK);
    #1;
  endtask

  initial begin
    step_t steps [NSTEP];
    int    base;

    steps[0]  = '{16'h0020, 6, 1, 4'h5, 16'h0005, 1'b1};
    steps[1]  = '{16'h0060, 4, 0, 4'h5, 16'h0005, 1'b1};
    steps[2]  = '{16'h0000, 4, 0, 4'h5, 16'h0005, 1'b0};
    steps[3]  = '{16'h0004, 6, 1, 4'h3, 16'h0053, 1'b1};
    steps[4]  = '{16'h0000, 4, 0, 4'h3, 16'h0053, 1'b0};
    steps[5]  = '{16'h0003, 5, 0, 4'h3, 16'h0053, 1'b1};
    steps[6]  = '{16'h0000, 4, 0, 4'h3, 16'h0053, 1'b0};
    steps[7]  = '{16'h0008, 5, 1, 4'hA, 16'h053A, 1'b1};
    steps[8]  = '{16'h0000, 4, 0, 4'hA, 16'h053A, 1'b0};
    steps[9]  = '{16'h0001, 5, 1, 4'h1, 16'h53A1, 1'b1};
    steps[10] = '{16'h0000, 4, 0, 4'h1, 16'h53A1, 1'b0};
    steps[11] = '{16'h0002, 5, 1, 4'h2, 16'h3A12, 1'b1};
    steps[12] = '{16'h0000, 4, 0, 4'h2, 16'h3A12, 1'b0};
    steps[13] = '{16'h0004, 5, 1, 4'h3, 16'hA123, 1'b1};
    steps[14] = '{16'h0000, 4, 0, 4'h3, 16'hA123, 1'b0};
    steps[15] = '{16'h0010, 5, 1, 4'h4, 16'h1234, 1'b1};
    steps[16] = '{16'h0000, 4, 0, 4'h4, 16'h1234, 1'b0};
    steps[17] = '{16'h0020, 5, 1, 4'h5, 16'h2345, 1'b1};
    steps[18] = '{16'h0000, 4, 0, 4'h5, 16'h2345, 1'b0};

    // Reset state and row scan cadence.
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_row", 32'(KP_ROW), 32'h0000_000E);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    $display("reset: row=%b data=%04h valid=%b held=%b", KP_ROW, data, key_valid, key_held);
    RSTN = 1'b1;
    repeat (7) @(posedge CLK); #1;
    check("row0_hold", 32'(KP_ROW), 32'h0000_000E);
    @(posedge CLK); #1;
    check("row1", 32'(KP_ROW), 32'h0000_000D);
    repeat (8) @(posedge CLK); #1;
    check("row2", 32'(KP_ROW), 32'h0000_000B);
    repeat (8) @(posedge CLK); #1;
    check("row3", 32'(KP_ROW), 32'h0000_0007);
    repeat (8) @(posedge CLK); #1;
    check("row_wrap", 32'(KP_ROW), 32'h0000_000E);
    $display("scan: row steps checked through one frame");

    // Frame-aligned table: single key, ignored added key, multi-key lockout, shift-out.
    for (int i = 0; i < NSTEP; i++) begin
      base = pulse_cnt;
      keys = steps[i].keys;
      wait_frames(steps[i].frames);
      $display("step %0d: keys=%04h frames=%0d pulses=%0d code=%h data=%04h held=%b",
               i, steps[i].keys, steps[i].frames, pulse_cnt - base, key_code, data, key_held);
      check($sformatf("step%0d_pulses", i), 32'(pulse_cnt - base), 32'(steps[i].pulses));
      check($sformatf("step%0d_code", i), 32'(key_code), 32'(steps[i].code));
      check($sformatf("step%0d_data", i), 32'(data), 32'(steps[i].data));
      check($sformatf("step%0d_held", i), 32'(key_held), 32'(steps[i].held));
    end

    // Bounce on key 7: five alternating frames, then held; pulse lands exactly
    // one cycle after the third identical frame ends.
    base = pulse_cnt;
    keys = 16'h0100; wait_frames(1);
    keys = 16'h0000; wait_frames(1);
    keys = 16'h0100; wait_frames(1);
    keys = 16'h0000; wait_frames(1);
    keys = 16'h0100; wait_frames(3);
    check("bounce_quiet", 32'(pulse_cnt - base), 32'h0);
    check("bounce_pre_valid", 32'(key_valid), 32'h0);
    @(posedge CLK); @(negedge CLK);
    check("bounce_pulse", 32'(key_valid), 32'h1);
    check("bounce_code", 32'(key_code), 32'h7);
    check("bounce_data", 32'(data), 32'h3457);
    @(negedge CLK);
    check("pulse_width", 32'(key_valid), 32'h0);
    repeat (30) @(posedge CLK); #1;
    check("bounce_count", 32'(pulse_cnt - base), 32'h1);
    $display("bounce: pulses=%0d code=%h data=%04h", pulse_cnt - base, key_code, data);
    keys = 16'h0000; wait_frames(4);
    check("bounce_release", 32'(key_held), 32'h0);

    // Reset while key 9 is held: state clears, key is re-accepted after debounce.
    keys = 16'h0400;
    wait_frames(5);
    check("pre_rst_held", 32'(key_held), 32'h1);
    check("pre_rst_data", 32'(data), 32'h4579);
    RSTN = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_held", 32'(key_held), 32'h0);
    check("midrst_valid", 32'(key_valid), 32'h0);
    check("midrst_code", 32'(key_code), 32'h0);
    check("midrst_row", 32'(KP_ROW), 32'h0000_000E);
    base = pulse_cnt;
    wait_frames(4);
    check("reaccept_pulses", 32'(pulse_cnt - base), 32'h1);
    check("reaccept_code", 32'(key_code), 32'h9);
    check("reaccept_data", 32'(data), 32'h0009);
    check("reaccept_held", 32'(key_held), 32'h1);
    $display("midreset: pulses=%0d code=%h data=%04h held=%b", pulse_cnt - base, key_code, data, key_held);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hex_keypad.md
# hex_keypad

Scanner and entry register for a 4x4 hexadecimal matrix keypad: the input-side counterpart of the multiplexed hex display driver. It drives keypad rows one at a time, samples the columns, debounces the full key snapshot, and emits one code per clean keypress. Each accepted digit is shifted into a 16-bit word that connects directly to the display driver's `data` input.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles per row slot. Minimum 4.
- `DEB_FRAMES`, 4: consecutive identical scan frames required before a snapshot counts as stable. Minimum 1.

Ports:
- `CLK`, in, 1: sole clock.
- `RSTN`, in, 1: reset. Synchronous, active-low.
- `KP_ROW`, out, 4: row drive, active-low, exactly one bit low at a time.
- `KP_COL`, in, 4: column sense, active-low (pulled up externally), asynchronous.
- `key_valid`, out, 1: one-cycle pulse when a key is accepted.
- `key_code`, out, 4: code of the last accepted key. Held between pulses.
- `key_held`, out, 1: high while the FSM is in HELD or LOCKED.
- `data`, out, 16: entry register. Newest digit in `[3:0]`.

## Operation
- Synchronize `KP_COL` through two flops before any use.
- Row scan:
  - Row index r cycles 0,1,2,3,0,…; `KP_ROW = ~(1<<r)`.
  - A slot counter runs 0..SCAN_DIV-1.
  - On count SCAN_DIV-1, capture `~col_sync` into `raw[4r+3:4r]`, then advance r.
- Frame end is the capture on r=3. At frame end:
  - If `raw == prev_raw`, then `same_cnt++`, saturating at DEB_FRAMES.
  - Otherwise `same_cnt = 1`.
  - In both cases, `prev_raw <= raw`.
  - When `same_cnt` reaches DEB_FRAMES, `stable <= raw` and the FSM evaluates once.
- Key map (row, col → code):
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: 0, F, E, D
- FSM, evaluated only on a stable update:
  - RELEASED:
    - stable==0: stay.
    - Exactly one bit set: emit, go to HELD.
    - Two or more bits set: go to LOCKED, no emit.
  - HELD:
    - stable==0: go to RELEASED.
    - Otherwise stay. No repeat; added keys are ignored.
  - LOCKED:
    - stable==0: go to RELEASED.
    - Otherwise stay.
- Emit: `key_code <= map`, `data <= {data[11:0], map}`, `key_valid` pulses. The oldest digit is discarded.
- Reset values:
  - `KP_ROW=4'b1110`, r=0, slot counter 0.
  - `raw=prev_raw=stable=0`, `same_cnt=0`.
  - FSM RELEASED.
  - `key_valid=0`, `key_code=0`, `key_held=0`, `data=16'h0000`.
- Reset mid-operation:
  - Everything returns to reset values and any pending emit is lost.
  - A key still held after reset is re-accepted once it passes debounce.

## Timing
- Frame length is 4·SCAN_DIV cycles. Each column sample sits SCAN_DIV-1 cycles after its row is driven, which leaves settle time plus the 2-cycle synchronizer delay.
- `key_valid`, `key_code` and `data` update on the same edge, one cycle after the frame-end capture. The pulse lasts exactly 1 cycle.
- Press-to-pulse latency:
  - Minimum DEB_FRAMES frames after the first frame that sees the key.
  - Maximum DEB_FRAMES+1 frames from the physical press.
- Release is detected after DEB_FRAMES identical all-zero frames. A new press can be accepted on the frame after that.
- Row changes and captures never coincide on the same edge for the same row.

## Structure
- Package `keypad_pkg`:
  - State enum {RELEASED, HELD, LOCKED}.
  - 16-entry key-map constant indexed by {row, col}.
  - Function returning the index of the single set bit, plus a one-hot check on the 16-bit snapshot.
- Sub-module `kp_debounce`:
  - Holds `prev_raw`, `same_cnt` and `stable`.
  - Inputs: `raw`, `frame_end`.
  - Outputs: `stable` and a one-cycle `stable_upd` strobe.
- Scan counter, synchronizer, FSM and entry register live in `hex_keypad`.

## Test plan
Bench uses SCAN_DIV=8 and DEB_FRAMES=3, giving a 32-cycle frame. The keypad model pulls the column low when the matching row is driven low.
- Reset: hold RSTN low for 2 cycles → `KP_ROW=1110`, `data=0000`, `key_valid=0`, `key_held=0`. After release, `KP_ROW` steps 1101, 1011, 0111 every 8 cycles.
- Single key: press row1/col1 for 6 frames, release for 4 frames, then press row0/col2 → exactly two pulses, `key_code` 5 then 3, `data=0x0053`.
- Bounce: toggle row2/col0 on alternate frames for 5 frames, then hold it → one pulse only, code 7, arriving 3 stable frames after the toggling stops.
- Multi-key: press 1 and 2 together → no pulse, `key_held=1`. Release both, then press A → one pulse, code A.
- Shift-out: enter 1, 2, 3, 4, 5 with full releases between them → `data=0x2345`.
- Reset mid-press: hold 9, pulse RSTN low for 1 cycle while in HELD → `data=0`, `key_held=0`. Then one pulse with code 9 and `data=0x0009` within 4 frames.
